// File: rtl/bus_register_slave_pkg.sv
// Shared types and constants for the IO_bus register slave.
// Bus direction encoding, status width and FSM state type.
package bus_register_slave_pkg;

    typedef logic [15:0] uint16_t;
    typedef logic [7:0]  byte_t;

    localparam logic BUS_READ          = 1'b1;
    localparam logic BUS_WRITE         = 1'b0;
    localparam int   STATUS_FLAG_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

endpackage

// File: rtl/bus_register_slave_fsm.sv
// Handshake sequencer for the IO_bus register slave.
// Idle -> one access cycle -> acknowledge until the strobe drops.
module bus_slave_FSM
    import bus_register_slave_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_handshake_1,
    output logic o_capture,
    output logic o_do_access,
    output logic o_ack
);

    state_t r_state;
    state_t w_next;
    logic   r_ack;

    // State register; acknowledge is registered so it trails S_ACK by one edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= (r_state == S_ACK);
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_next      = r_state;
        o_capture   = 1'b0;
        o_do_access = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_next    = S_ACCESS;
                    o_capture = 1'b1;
                end
            end
            S_ACCESS: begin
                o_do_access = 1'b1;
                w_next      = S_ACK;
            end
            S_ACK: begin
                if (!i_handshake_1) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign o_ack = r_ack;

endmodule

// File: rtl/bus_register_slave.sv
// Register-bank slave on the 32-bit IO_bus.
// NUM_REGS-1 control words plus a read-only STATUS word at the top index.
module bus_register_slave
    import bus_register_slave_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'd0,
    parameter int         NUM_REGS  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           handshake_1,
    output logic                           handshake_2,
    input  logic                           RW,
    input  logic                           register_address_valid,
    input  logic [7:0]                     reg_address,
    input  logic [31:0]                    data_out,
    output logic [31:0]                    data_in,
    output logic                           nFault,
    input  logic [STATUS_FLAG_WIDTH-1:0]   status_in,
    output logic [32*(NUM_REGS-1)-1:0]     ctrl_regs
);

    localparam int         NCTRL      = NUM_REGS - 1;
    localparam logic [7:0] NR         = 8'(NUM_REGS);
    localparam logic [7:0] STATUS_IDX = 8'(NUM_REGS - 1);

    logic [7:0]  w_offset;
    logic        w_hit;
    logic        w_capture;
    logic        w_do_access;
    logic [31:0] w_rd_word;

    byte_t       r_index;
    byte_t       r_last_index;
    logic        r_rw;
    logic [31:0] r_wdata;
    uint16_t     r_trans_count;
    logic [31:0] r_regs [NCTRL];
    logic [31:0] r_data_in;
    logic        r_nfault;

    // Unsigned 8-bit offset: addresses below the base wrap high and miss
    assign w_offset = reg_address - BASE_ADDR;
    assign w_hit    = register_address_valid && (w_offset < NR);

    bus_slave_FSM u_fsm (
        .clk           (clk),
        .reset         (reset),
        .i_req         (handshake_1 && w_hit),
        .i_handshake_1 (handshake_1),
        .o_capture     (w_capture),
        .o_do_access   (w_do_access),
        .o_ack         (handshake_2)
    );

    // Latch the request so later bus changes cannot disturb the access
    always_ff @(posedge clk) begin
        if (reset) begin
            r_index <= '0;
            r_rw    <= BUS_WRITE;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_index <= w_offset;
            r_rw    <= RW;
            r_wdata <= data_out;
        end
    end

    // Read mux: STATUS word unless the index selects a control word
    always_comb begin
        w_rd_word = {r_trans_count, r_last_index, status_in};
        for (int i = 0; i < NCTRL; i++) begin
            if (r_index == 8'(i)) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    // Access cycle: register update, read return, fault flag, counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trans_count <= '0;
            r_last_index  <= '0;
            r_data_in     <= '0;
            r_nfault      <= 1'b1;
            for (int i = 0; i < NCTRL; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_do_access) begin
            r_trans_count <= r_trans_count + 16'd1;
            r_last_index  <= r_index;
            if (r_rw == BUS_READ) begin
                r_data_in <= w_rd_word;
                r_nfault  <= 1'b1;
            end else if (r_index == STATUS_IDX) begin
                r_nfault <= 1'b0;
            end else begin
                r_nfault <= 1'b1;
                for (int i = 0; i < NCTRL; i++) begin
                    if (r_index == 8'(i)) begin
                        r_regs[i] <= r_wdata;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NCTRL; g++) begin : g_ctrl
        assign ctrl_regs[g*32 +: 32] = r_regs[g];
    end

    assign data_in = r_data_in;
    assign nFault  = r_nfault;

endmodule

// File: tb/tb_bus_register_slave.sv
// Directed bench for bus_register_slave with a transaction-level model.
// Model updates at the expected access edge; outputs compared every cycle.
module tb_bus_register_slave;

    localparam logic [7:0] BASE = 8'h10;
    localparam int         NR   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        handshake_1;
    logic        handshake_2;
    logic        RW;
    logic        register_address_valid;
    logic [7:0]  reg_address;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        nFault;
    logic [7:0]  status_in;
    logic [95:0] ctrl_regs;

    bus_register_slave #(.BASE_ADDR(BASE), .NUM_REGS(NR)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .handshake_1            (handshake_1),
        .handshake_2            (handshake_2),
        .RW                     (RW),
        .register_address_valid (register_address_valid),
        .reg_address            (reg_address),
        .data_out               (data_out),
        .data_in                (data_in),
        .nFault                 (nFault),
        .status_in              (status_in),
        .ctrl_regs              (ctrl_regs)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    logic [31:0] m_regs [3];
    logic [15:0] m_count;
    logic [7:0]  m_last;
    logic [31:0] m_din;
    logic        m_nf;
    logic        exp_hs2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_regs[i] = '0;
        m_count = '0;
        m_last  = '0;
        m_din   = '0;
        m_nf    = 1'b1;
        exp_hs2 = 1'b0;
    endtask

    task automatic m_access(input logic rw, input logic [7:0] off, input logic [31:0] wd);
        if (off == 8'(NR - 1)) begin
            if (rw) begin
                m_din = {m_count, m_last, status_in};
                m_nf  = 1'b1;
            end else begin
                m_nf = 1'b0;
            end
        end else begin
            if (rw) m_din = m_regs[off[1:0]];
            else    m_regs[off[1:0]] = wd;
            m_nf = 1'b1;
        end
        m_last  = off;
        m_count = m_count + 16'd1;
    endtask

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("handshake_2", {31'd0, handshake_2}, {31'd0, exp_hs2});
            chk("nFault", {31'd0, nFault}, {31'd0, m_nf});
            chk("data_in", data_in, m_din);
            for (int i = 0; i < 3; i++)
                chk($sformatf("ctrl%0d", i), ctrl_regs[i*32 +: 32], m_regs[i]);
        end
    end

    // mode 0: normal, 1: strobe drops during access, 2: reset during ack
    task automatic txn(input logic rw, input logic [7:0] addr, input logic [31:0] wd,
                       input logic av, input int mode, output logic [31:0] rd);
        logic [7:0] off;
        off = addr - BASE;
        rd  = '0;
        @(negedge clk);
        handshake_1 = 1'b1;
        RW = rw;
        reg_address = addr;
        data_out = wd;
        register_address_valid = av;
        if (!(av && off < 8'(NR))) begin
            repeat (20) @(negedge clk);
            handshake_1 = 1'b0;
            register_address_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        reg_address = ~addr;
        register_address_valid = 1'b0;
        data_out = ~wd;
        RW = ~rw;
        if (mode == 1) handshake_1 = 1'b0;
        @(posedge clk);
        #1 m_access(rw, off, wd);
        @(posedge clk);
        #1 exp_hs2 = 1'b1;
        rd = data_in;
        if (mode == 1) begin
            @(posedge clk);
            #1 exp_hs2 = 1'b0;
            return;
        end
        @(negedge clk);
        handshake_1 = 1'b0;
        if (mode == 2) begin
            reset = 1'b1;
            @(posedge clk);
            #1 m_reset();
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        @(posedge clk);
        @(posedge clk);
        #1 exp_hs2 = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        m_reset();
        reset = 1'b1;
        handshake_1 = 1'b0;
        RW = 1'b0;
        register_address_valid = 1'b0;
        reg_address = '0;
        data_out = '0;
        status_in = 8'h3C;
        repeat (2) @(posedge clk);
        #1 chk_on = 1'b1;
        chk("rst_hs2", {31'd0, handshake_2}, 32'd0);
        chk("rst_nfault", {31'd0, nFault}, 32'd1);
        chk("rst_din", data_in, 32'd0);
        chk("rst_ctrl", {31'd0, ctrl_regs == 96'd0}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        txn(1'b0, 8'h11, 32'hDEADBEEF, 1'b1, 0, rd);
        chk("w1_word1", ctrl_regs[63:32], 32'hDEADBEEF);
        chk("w1_nfault", {31'd0, nFault}, 32'd1);
        txn(1'b1, 8'h11, 32'h0, 1'b1, 0, rd);
        chk("r1_data", rd, 32'hDEADBEEF);
        txn(1'b0, 8'h10, 32'hCAFEF00D, 1'b1, 0, rd);
        txn(1'b0, 8'h12, 32'h000000FF, 1'b1, 0, rd);
        txn(1'b1, 8'h13, 32'h0, 1'b1, 0, rd);
        chk("status_a", rd, 32'h0004_023C);
        txn(1'b0, 8'h13, 32'h12345678, 1'b1, 0, rd);
        chk("fault_lo", {31'd0, nFault}, 32'd0);
        chk("fault_keep", {31'd0, ctrl_regs == {32'hFF, 32'hDEADBEEF, 32'hCAFEF00D}}, 32'd1);
        txn(1'b1, 8'h10, 32'h0, 1'b1, 0, rd);
        chk("fault_clr", {31'd0, nFault}, 32'd1);
        chk("r0_data", rd, 32'hCAFEF00D);

        txn(1'b0, 8'h14, 32'h1, 1'b1, 0, rd);
        txn(1'b0, 8'h0F, 32'h2, 1'b1, 0, rd);
        txn(1'b1, 8'h11, 32'h3, 1'b0, 0, rd);
        txn(1'b1, 8'h13, 32'h0, 1'b1, 0, rd);
        chk("miss_count", rd, 32'h0007_003C);

        txn(1'b1, 8'h12, 32'h0, 1'b1, 1, rd);
        chk("early_drop", rd, 32'h000000FF);

        status_in = 8'hA5;
        @(negedge clk);
        force dut.r_trans_count = 16'hFFFF;
        @(posedge clk);
        #1 release dut.r_trans_count;
        m_count = 16'hFFFF;
        txn(1'b1, 8'h13, 32'h0, 1'b1, 0, rd);
        chk("status_ffff", rd, 32'hFFFF_02A5);
        txn(1'b1, 8'h13, 32'h0, 1'b1, 0, rd);
        chk("status_wrap", rd, 32'h0000_03A5);

        txn(1'b0, 8'h10, 32'h55AA55AA, 1'b1, 2, rd);
        chk("rst_ack_hs2", {31'd0, handshake_2}, 32'd0);
        chk("rst_ack_ctrl", {31'd0, ctrl_regs == 96'd0}, 32'd1);
        txn(1'b0, 8'h11, 32'h01234567, 1'b1, 0, rd);
        txn(1'b1, 8'h13, 32'h0, 1'b1, 0, rd);
        chk("post_rst_status", rd, 32'h0001_01A5);
        txn(1'b1, 8'h11, 32'h0, 1'b1, 0, rd);
        chk("post_rst_read", rd, 32'h01234567);

        repeat (3) @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
